// File: rtl/crossbar_arbiter.sv
// N x N crossbar arbiter: each output grants one input for a whole packet,
// choosing among contending inputs round-robin from a per-output pointer.
module crossbar_arbiter #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_dest,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  input  logic [N-1:0]   out_ready,
  output logic [N-1:0]   out_valid,
  output logic [N*N-1:0] sel
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         r_state [N];
  logic [N-1:0]   r_grant [N];
  logic [W-1:0]   r_ptr   [N];

  state_t         w_nextState [N];
  logic [N-1:0]   w_nextGrant [N];
  logic [W-1:0]   w_nextPtr   [N];
  logic [N-1:0]   w_cand      [N];
  logic [N-1:0]   w_inUse;
  logic [N-1:0]   w_xfer;
  logic [N-1:0]   w_lastXfer;

  // An input already owned by a busy output is never offered to another one.
  always_comb begin
    w_inUse = '0;
    for (int o = 0; o < N; o++) begin
      if (r_state[o] == BUSY) w_inUse = w_inUse | r_grant[o];
    end
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++) begin
        w_cand[o][i] = req_valid[i] && (req_dest[i*W +: W] == W'(o)) && !w_inUse[i];
      end
    end
  end

  always_comb begin
    out_valid  = '0;
    req_ready  = '0;
    sel        = '0;
    w_xfer     = '0;
    w_lastXfer = '0;
    for (int o = 0; o < N; o++) begin
      if (r_state[o] == BUSY) begin
        sel[o*N +: N] = r_grant[o];
        out_valid[o]  = |(r_grant[o] & req_valid);
        req_ready     = req_ready | (r_grant[o] & {N{out_ready[o]}});
        w_xfer[o]     = out_valid[o] & out_ready[o];
        w_lastXfer[o] = w_xfer[o] & (|(r_grant[o] & req_last));
      end
    end
  end

  always_comb begin : p_next
    logic found;
    int   idx;
    for (int o = 0; o < N; o++) begin
      w_nextState[o] = r_state[o];
      w_nextGrant[o] = r_grant[o];
      w_nextPtr[o]   = r_ptr[o];
      found          = 1'b0;
      idx            = 0;
      case (r_state[o])
        IDLE: begin
          // Scan candidates starting at the pointer, wrapping around.
          for (int j = 0; j < N; j++) begin
            idx = (int'(r_ptr[o]) + j) % N;
            for (int i = 0; i < N; i++) begin
              if (!found && (i == idx) && w_cand[o][i]) begin
                found          = 1'b1;
                w_nextGrant[o] = '0;
                w_nextGrant[o][i] = 1'b1;
              end
            end
          end
          if (found) w_nextState[o] = BUSY;
        end
        BUSY: begin
          if (w_lastXfer[o]) begin
            w_nextState[o] = IDLE;
            w_nextGrant[o] = '0;
            for (int i = 0; i < N; i++) begin
              if (r_grant[o][i]) w_nextPtr[o] = W'((i + 1) % N);
            end
          end
        end
        default: w_nextState[o] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int o = 0; o < N; o++) begin
        r_state[o] <= IDLE;
        r_grant[o] <= '0;
        r_ptr[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < N; o++) begin
        r_state[o] <= w_nextState[o];
        r_grant[o] <= w_nextGrant[o];
        r_ptr[o]   <= w_nextPtr[o];
      end
    end
  end

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Directed self-checking bench for crossbar_arbiter with N=4.
module tb_crossbar_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic           clk = 1'b0;
  logic           nreset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_dest;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   out_ready;
  logic [N-1:0]   out_valid;
  logic [N*N-1:0] sel;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [15:0] contExp [9];
  logic [4:0]  bpPat;

  always #5 clk = ~clk;

  crossbar_arbiter #(.N(N)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .req_valid (req_valid),
    .req_dest  (req_dest),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .sel       (sel)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the falling edge; checks follow 1 time unit later.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] d,
                               input logic [N-1:0] l, input logic [N-1:0] r);
    req_valid = v;
    req_dest  = d;
    req_last  = l;
    out_ready = r;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    contExp = '{16'h0001, 16'h0000, 16'h0002, 16'h0000, 16'h0008,
                16'h0000, 16'h0001, 16'h0000, 16'h0002};
    bpPat   = 5'b10101;

    // Reset held with every input requesting.
    nreset    = 1'b0;
    req_valid = 4'hF;
    req_dest  = '0;
    req_last  = 4'hF;
    out_ready = 4'hF;
    nextCycle();
    for (int k = 0; k < 3; k++) begin
      checkOutput("reset_sel", sel, 16'h0000);
      checkOutput("reset_out_valid", out_valid, 4'b0000);
      checkOutput("reset_req_ready", req_ready, 4'b0000);
      nextCycle();
    end

    // Single-beat packet, input 2 to output 1.
    nreset = 1'b1;
    applyStimulus(4'b0100, 8'b0001_0000, 4'b0100, 4'hF);
    checkOutput("single_pre_sel", sel, 16'h0000);
    nextCycle();
    checkOutput("single_sel", sel, 16'h0040);
    checkOutput("single_out_valid", out_valid, 4'b0010);
    checkOutput("single_req_ready", req_ready, 4'b0100);
    nextCycle();
    applyStimulus(4'b0000, 8'h00, 4'b0000, 4'hF);
    checkOutput("single_after_sel", sel, 16'h0000);
    checkOutput("single_after_out_valid", out_valid, 4'b0000);

    // Contention on output 0 from inputs 0, 1 and 3.
    applyStimulus(4'b1011, 8'h00, 4'b1011, 4'hF);
    for (int k = 0; k < 9; k++) begin
      nextCycle();
      checkOutput("contention_sel", sel, contExp[k]);
    end
    nextCycle();
    applyStimulus(4'b0000, 8'h00, 4'b0000, 4'hF);
    checkOutput("contention_end_sel", sel, 16'h0000);

    // Three-beat packet, input 1 to output 3, under backpressure.
    applyStimulus(4'b0010, 8'b0000_1100, 4'b0000, 4'b0000);
    nextCycle();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b0010, 8'b0000_1100, (c == 4) ? 4'b0010 : 4'b0000,
                    {bpPat[c], 3'b000});
      checkOutput("bp_sel", sel, 16'h2000);
      checkOutput("bp_out_valid", out_valid, 4'b1000);
      checkOutput("bp_req_ready", req_ready, {2'b00, bpPat[c], 1'b0});
      nextCycle();
    end
    applyStimulus(4'b0000, 8'h00, 4'b0000, 4'hF);
    checkOutput("bp_release_sel", sel, 16'h0000);

    // Parallel grants: input 0 to output 2, input 1 to output 3.
    applyStimulus(4'b0011, 8'b0000_1110, 4'b0011, 4'hF);
    nextCycle();
    checkOutput("parallel_sel", sel, 16'h2100);
    checkOutput("parallel_out_valid", out_valid, 4'b1100);
    checkOutput("parallel_req_ready", req_ready, 4'b0011);
    nextCycle();
    applyStimulus(4'b0000, 8'h00, 4'b0000, 4'hF);
    checkOutput("parallel_end_sel", sel, 16'h0000);

    // Four-beat packet from input 0 cut off by reset during beat 2.
    applyStimulus(4'b0001, 8'h00, 4'b0000, 4'hF);
    nextCycle();
    checkOutput("midrst_beat1_sel", sel, 16'h0001);
    nextCycle();
    checkOutput("midrst_beat2_sel", sel, 16'h0001);
    nreset = 1'b0;
    nextCycle();
    nreset = 1'b1;
    applyStimulus(4'b1000, 8'h00, 4'b1000, 4'hF);
    checkOutput("midrst_after_sel", sel, 16'h0000);
    checkOutput("midrst_after_req_ready", req_ready, 4'b0000);
    nextCycle();
    checkOutput("midrst_in3_sel", sel, 16'h0008);
    checkOutput("midrst_in3_req_ready", req_ready, 4'b1000);
    applyStimulus(4'b1001, 8'h00, 4'b1001, 4'hF);
    nextCycle();
    applyStimulus(4'b0001, 8'h00, 4'b0001, 4'hF);
    checkOutput("midrst_gap_sel", sel, 16'h0000);
    nextCycle();
    checkOutput("midrst_in0_sel", sel, 16'h0001);
    nextCycle();
    applyStimulus(4'b0000, 8'h00, 4'b0000, 4'hF);
    checkOutput("midrst_end_sel", sel, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/crossbar_arbiter.md
CROSSBAR_ARBITER -- requirements
Module: crossbar_arbiter

Interface
REQ-001 SHALL have parameter: N, 4, number of crossbar inputs and outputs (N >= 2); W = clog2(N) is the derived destination-index width.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: nreset  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: req_valid  input  N  per-input request/beat valid.
REQ-005 SHALL have port: req_dest  input  N*W  per-input destination output index; field i is [i*W +: W].
REQ-006 SHALL have port: req_last  input  N  per-input final beat of a packet.
REQ-007 SHALL have port: req_ready  output  N  per-input beat accepted.
REQ-008 SHALL have port: out_ready  input  N  per-output downstream ready.
REQ-009 SHALL have port: out_valid  output  N  per-output beat valid toward downstream.
REQ-010 SHALL have port: sel  output  N*N  crossbar select; field o is [o*N +: N], one-hot with input index, or all-zero.

Function
REQ-011 SHALL keep, per output o, a state IDLE/BUSY, an N-bit one-hot registered grant g[o], and a W-bit round-robin pointer p[o].
REQ-012 Candidate set of output o SHALL be the inputs i with req_valid[i]=1 and req_dest field i == o.
REQ-013 In IDLE with a non-empty candidate set, the winner SHALL be the first candidate scanning i = p[o], p[o]+1, ... mod N; the next edge loads g[o] and moves to BUSY.
REQ-014 In IDLE with an empty candidate set, output o SHALL stay IDLE and g[o] SHALL stay zero.
REQ-015 Arbitration latency SHALL be exactly one cycle: a request seen at edge k yields sel/out_valid after edge k.
REQ-016 In BUSY, sel[o*N +: N] SHALL equal g[o]; in IDLE, it SHALL be zero.
REQ-017 In BUSY with granted input i: out_valid[o] = req_valid[i]; req_ready[i] = out_ready[o] (combinational).
REQ-018 req_ready[i] SHALL be 0 for any input not currently granted; out_valid[o] SHALL be 0 in IDLE.
REQ-019 Transfer on output o SHALL occur when out_valid[o] and out_ready[o] are both 1.
REQ-020 A transfer with req_last[i]=1 SHALL return o to IDLE and set p[o] = (i+1) mod N at the same edge; other transfers SHALL keep BUSY and g[o].
REQ-021 The grant SHALL be held across req_valid deassertion gaps mid-packet (no re-arbitration until last).
REQ-022 After a last beat at edge k, output o SHALL be IDLE for cycle k..k+1 and can re-grant earliest after edge k+1 (minimum one idle cycle between packets).
REQ-023 Outputs SHALL arbitrate independently; different outputs SHALL grant in the same cycle when their winners differ.
REQ-024 A requester SHALL hold req_dest stable from first req_valid to its last transfer; changing it mid-packet SHALL be a protocol violation (behaviour unspecified).
REQ-025 At most one bit of each sel field SHALL be set at any time; no input SHALL be granted by two outputs.

Reset
REQ-026 While nreset=0 at a rising edge: all outputs IDLE, g=0, p=0 for every output.
REQ-027 Immediately after reset: sel=0, out_valid=0, req_ready=0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet; sel=0 after that edge; arbitration restarts with pointer 0.

Verification (N=4)
REQ-029 SHALL cover reset: nreset=0 with all req_valid=1 for 3 cycles -> sel=16'h0000, out_valid=0, req_ready=0 throughout.
REQ-030 SHALL cover single packet: input 2, dest 1, req_last=1, out_ready=1 -> one cycle later sel=16'h0040, out_valid[1]=1, req_ready[2]=1; next cycle sel=0.
REQ-031 SHALL cover contention: inputs 0,1,3 continuously request dest 0 with single-beat packets, out_ready=1 -> grant order 0,1,3,0,1, one idle cycle between grants.
REQ-032 SHALL cover backpressure: input 1 -> output 3, 3 beats, out_ready[3] pattern 1,0,1,0,1 -> sel[15:12]=4'b0010 held for 5 cycles; req_ready[1] mirrors out_ready[3]; release after third transfer.
REQ-033 SHALL cover parallel grants: input 0 -> output 2 and input 1 -> output 3 in the same cycle -> sel=16'h2100 one cycle later.
REQ-034 SHALL cover mid-packet reset: during beat 2 of a 4-beat packet, nreset=0 for one edge -> sel=0 next cycle; new request from input 3 to output 0 then granted before input 0 when both request.
